ysyx22040413_wbu: RTL and testbench
===================================

YSYX22040413_WBU -- requirements
Module: ysyx22040413_WBU

Interface
REQ-001 SHALL have parameter XLEN, default 64: width of result data and register-file write data.
REQ-002 SHALL have parameter CNT_W, default 32: width of the retire counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port ex_valid, input, 1: the execute stage presents a result this cycle.
REQ-006 SHALL have port ex_ready, output, 1: this block accepts the presented result this cycle.
REQ-007 SHALL have port ex_inst_type, input, 5: instruction type from execute.
REQ-008 SHALL have port ex_rd_wen, input, 1: instruction writes rd.
REQ-009 SHALL have port ex_rd_addr, input, 5: destination register index.
REQ-010 SHALL have port ex_rd_data, input, XLEN: execute result.
REQ-011 SHALL have port flush, input, 1: discard all buffered results.
REQ-012 SHALL have port wb_ready, input, 1: the register-file write port is available this cycle.
REQ-013 SHALL have port wb_valid, output, 1: a buffered result is presented for retirement.
REQ-014 SHALL have port wb_inst_type, output, 5: instruction type of the head entry.
REQ-015 SHALL have port rf_wen, output, 1: register-file write strobe.
REQ-016 SHALL have port rf_waddr, output, 5: register-file write index.
REQ-017 SHALL have port rf_wdata, output, XLEN: register-file write data.
REQ-018 SHALL have port retire_cnt, output, CNT_W: count of retired instructions.

Function
REQ-019 SHALL buffer results in a 2-entry FIFO, with read/write pointers wrapping 1->0 and an occupancy count ranging 0..2.
REQ-020 SHALL drive ex_ready = (occupancy < 2) AND rst high; ex_ready SHALL NOT depend combinationally on wb_ready or ex_valid.
REQ-021 SHALL push {ex_inst_type, ex_rd_wen, ex_rd_addr, ex_rd_data} on an edge where ex_valid && ex_ready && !flush.
REQ-022 SHALL drive wb_valid = (occupancy > 0); wb_inst_type, rf_waddr and rf_wdata SHALL show the head entry; these outputs are don't-care when wb_valid is 0.
REQ-023 SHALL drive rf_wen = wb_valid && wb_ready && head.rd_wen && (head.rd_addr != 0).
REQ-024 SHALL pop the head on an edge where wb_valid && wb_ready && !flush.
REQ-025 Latency: a result accepted at edge N SHALL be presented on wb_valid in the cycle after edge N; there is no same-cycle bypass from ex_* to wb_*.
REQ-026 Simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1, with the new entry becoming head after the pop.
REQ-027 When occupancy is 2, push SHALL be blocked; a pop in the same cycle frees a slot visible as ex_ready=1 in the next cycle.
REQ-028 When occupancy is 0, a pop SHALL NOT occur because wb_valid is 0.
REQ-029 A write to x0 (rd_addr=0) or an entry with rd_wen=0 SHALL still pop and retire, with rf_wen held low.
REQ-030 retire_cnt SHALL increment by 1 on every pop and wrap from all-ones to 0.
REQ-031 flush SHALL clear occupancy and pointers to 0 at the next edge, overriding any push or pop in that cycle.
REQ-032 A flush SHALL NOT increment retire_cnt and SHALL NOT assert rf_wen in the flush cycle.
REQ-033 Entry payload registers SHALL be written only on push and need no reset.

Reset
REQ-034 On rst low, occupancy, pointers and retire_cnt SHALL clear immediately, independent of clk.
REQ-035 While rst is low: wb_valid=0, rf_wen=0, ex_ready=0, retire_cnt=0.
REQ-036 Reset asserted mid-operation SHALL discard all buffered entries, with no rf_wen pulse.
REQ-037 The first push SHALL be possible on the first rising edge after rst goes high.

Verification
REQ-038 Single push of {wen=1, addr=5, data=0x1234} at edge N with wb_ready=1 -> in the cycle after edge N: wb_valid=1, rf_wen=1, rf_waddr=5, rf_wdata=0x1234; retire_cnt=1 after the next edge.
REQ-039 wb_ready=0 while pushing A, B, C on consecutive cycles -> A and B accepted, ex_ready=0 once occupancy is 2, C stalled; raising wb_ready retires A, B, C in order.
REQ-040 Push with addr=0, wen=1 -> wb_valid=1, rf_wen=0, retire_cnt increments.
REQ-041 Occupancy 2, flush=1 with ex_valid=1 and wb_ready=1 -> next cycle occupancy 0, wb_valid=0, retire_cnt unchanged, no rf_wen pulse.
REQ-042 retire_cnt preloaded via 2^CNT_W - 1 retirements (or CNT_W=4 with 15 retirements) -> the next pop wraps it to 0.
REQ-043 rst pulled low between clock edges with occupancy 1 -> wb_valid and rf_wen drop immediately; after release, occupancy is 0 and ex_ready=1.

Source files
------------

// File: rtl/ysyx22040413_wbu.sv
// Write-back unit: a 2-entry result buffer between execute and the register
// file. Results accepted from execute retire in order, drive the register-file
// write port, and bump a free-running retire counter.
module ysyx22040413_wbu #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [4:0]       ex_inst_type,
  input  logic             ex_rd_wen,
  input  logic [4:0]       ex_rd_addr,
  input  logic [XLEN-1:0]  ex_rd_data,
  input  logic             flush,
  input  logic             wb_ready,
  output logic             wb_valid,
  output logic [4:0]       wb_inst_type,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [CNT_W-1:0] retire_cnt
);

  // Entry layout: {inst_type[4:0], rd_wen, rd_addr[4:0], rd_data[XLEN-1:0]}
  localparam int EW = 5 + 1 + 5 + XLEN;

  logic [EW-1:0]    entry_q [2];
  logic [EW-1:0]    entry_d [2];
  logic [1:0]       count_q, count_d;
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  logic [EW-1:0]    head;
  logic             head_wen;
  logic [4:0]       head_addr;
  logic             push;
  logic             pop;

  // Handshakes and head-entry decode; flush suppresses both push and pop
  always_comb begin
    head         = entry_q[rptr_q];
    head_wen     = head[XLEN+5];
    head_addr    = head[XLEN+4:XLEN];
    ex_ready     = (count_q < 2'd2) && rst;
    wb_valid     = (count_q != 2'd0);
    push         = ex_valid && ex_ready && !flush;
    pop          = wb_valid && wb_ready && !flush;
    wb_inst_type = head[EW-1:EW-5];
    rf_waddr     = head_addr;
    rf_wdata     = head[XLEN-1:0];
    rf_wen       = pop && head_wen && (head_addr != 5'd0);
    retire_cnt   = retire_cnt_q;
  end

  // Next-state for occupancy, pointers and retire counter
  always_comb begin
    count_d      = count_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    retire_cnt_d = retire_cnt_q;
    if (flush) begin
      count_d = 2'd0;
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
    end else begin
      if (push) begin
        wptr_d = ~wptr_q;
      end
      if (pop) begin
        rptr_d       = ~rptr_q;
        retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Payload next-state: only the slot under the write pointer changes, on push
  always_comb begin
    entry_d[0] = entry_q[0];
    entry_d[1] = entry_q[1];
    if (push) begin
      entry_d[wptr_q] = {ex_inst_type, ex_rd_wen, ex_rd_addr, ex_rd_data};
    end
  end

  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q      <= 2'd0;
      wptr_q       <= 1'b0;
      rptr_q       <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      count_q      <= count_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Payload storage is never reset; stale contents are hidden by wb_valid
  always_ff @(posedge clk) begin
    entry_q[0] <= entry_d[0];
    entry_q[1] <= entry_d[1];
  end

endmodule

// File: tb/tb_ysyx22040413_wbu.sv
// Bench for the write-back unit: a queue model of the 2-entry buffer predicts
// handshakes, head contents, register-file strobes and the retire counter.
module tb_ysyx22040413_wbu;

  typedef struct packed {
    logic [4:0]  t;
    logic        wen;
    logic [4:0]  addr;
    logic [63:0] data;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_inst_type;
  logic        ex_rd_wen;
  logic [4:0]  ex_rd_addr;
  logic [63:0] ex_rd_data;
  logic        flush;
  logic        wb_ready;
  logic        wb_valid;
  logic [4:0]  wb_inst_type;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [3:0]  retire_cnt;

  ent_t        sb[$];
  logic [3:0]  retire_model;
  int          n_checks;
  int          n_fail;

  ysyx22040413_wbu #(.XLEN(64), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_inst_type(ex_inst_type), .ex_rd_wen(ex_rd_wen),
    .ex_rd_addr(ex_rd_addr), .ex_rd_data(ex_rd_data),
    .flush(flush), .wb_ready(wb_ready), .wb_valid(wb_valid),
    .wb_inst_type(wb_inst_type), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .retire_cnt(retire_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle at the falling edge, check outputs, advance the model
  task automatic apply_stimulus(input logic v, input ent_t e, input logic wr,
                                input logic fl, output logic accepted);
    ent_t head;
    logic exp_ready;
    logic exp_wen;
    logic do_pop;
    ex_valid     = v;
    ex_inst_type = e.t;
    ex_rd_wen    = e.wen;
    ex_rd_addr   = e.addr;
    ex_rd_data   = e.data;
    wb_ready     = wr;
    flush        = fl;
    #1;
    head      = '0;
    exp_ready = (sb.size() < 2);
    check_output("ex_ready", {63'd0, ex_ready}, {63'd0, exp_ready});
    check_output("wb_valid", {63'd0, wb_valid}, {63'd0, sb.size() > 0});
    if (sb.size() > 0) begin
      head = sb[0];
      check_output("wb_inst_type", {59'd0, wb_inst_type}, {59'd0, head.t});
      check_output("rf_waddr", {59'd0, rf_waddr}, {59'd0, head.addr});
      check_output("rf_wdata", rf_wdata, head.data);
    end
    exp_wen = (sb.size() > 0) && wr && head.wen && (head.addr != 5'd0) && !fl;
    check_output("rf_wen", {63'd0, rf_wen}, {63'd0, exp_wen});
    check_output("retire_cnt", {60'd0, retire_cnt}, {60'd0, retire_model});
    accepted = v && exp_ready && !fl;
    do_pop   = (sb.size() > 0) && wr && !fl;
    if (fl) begin
      sb.delete();
    end else begin
      if (do_pop) begin
        void'(sb.pop_front());
        retire_model = retire_model + 4'd1;
      end
      if (accepted) sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic ent_t mk(input logic [4:0] t, input logic wen,
                              input logic [4:0] addr, input logic [63:0] data);
    ent_t e;
    e.t = t; e.wen = wen; e.addr = addr; e.data = data;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.t    = 5'($urandom_range(0, 31));
    e.wen  = 1'($urandom_range(0, 1));
    e.addr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    e.data = {32'($urandom), 32'($urandom)};
    return e;
  endfunction

  initial begin
    logic acc;
    int   guard;
    n_checks     = 0;
    n_fail       = 0;
    retire_model = 4'd0;
    rst          = 1'b0;
    ex_valid     = 1'b1;
    ex_inst_type = 5'd3;
    ex_rd_wen    = 1'b1;
    ex_rd_addr   = 5'd7;
    ex_rd_data   = 64'hdead;
    flush        = 1'b0;
    wb_ready     = 1'b1;

    // Held in reset across edges: everything quiet despite active inputs
    @(posedge clk);
    @(negedge clk);
    check_output("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check_output("rst_rf_wen", {63'd0, rf_wen}, 64'd0);
    check_output("rst_ex_ready", {63'd0, ex_ready}, 64'd0);
    check_output("rst_retire_cnt", {60'd0, retire_cnt}, 64'd0);
    rst = 1'b1;

    // Single push on the first edge after release, retired the next cycle
    apply_stimulus(1'b1, mk(5'd1, 1'b1, 5'd5, 64'h1234), 1'b1, 1'b0, acc);
    check_output("first_push_acc", {63'd0, acc}, 64'd1);
    apply_stimulus(1'b0, mk(5'd0, 1'b0, 5'd0, 64'd0), 1'b1, 1'b0, acc);
    apply_stimulus(1'b0, mk(5'd0, 1'b0, 5'd0, 64'd0), 1'b1, 1'b0, acc);

    // A, B accepted with write port stalled; C blocked while full
    apply_stimulus(1'b1, mk(5'd2, 1'b1, 5'd10, 64'hAAAA), 1'b0, 1'b0, acc);
    apply_stimulus(1'b1, mk(5'd3, 1'b1, 5'd11, 64'hBBBB), 1'b0, 1'b0, acc);
    apply_stimulus(1'b1, mk(5'd4, 1'b1, 5'd12, 64'hCCCC), 1'b0, 1'b0, acc);
    check_output("full_c_blocked", {63'd0, acc}, 64'd0);
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 8) begin
      apply_stimulus(1'b1, mk(5'd4, 1'b1, 5'd12, 64'hCCCC), 1'b1, 1'b0, acc);
      guard++;
    end
    check_output("c_eventually_acc", {63'd0, acc}, 64'd1);
    repeat (3) apply_stimulus(1'b0, mk(5'd0, 1'b0, 5'd0, 64'd0), 1'b1, 1'b0, acc);

    // Write to x0 and a non-writing entry both retire with rf_wen low
    apply_stimulus(1'b1, mk(5'd5, 1'b1, 5'd0, 64'h5555), 1'b1, 1'b0, acc);
    apply_stimulus(1'b1, mk(5'd6, 1'b0, 5'd9, 64'h6666), 1'b1, 1'b0, acc);
    repeat (2) apply_stimulus(1'b0, mk(5'd0, 1'b0, 5'd0, 64'd0), 1'b1, 1'b0, acc);

    // Flush while full with push and pop both requested
    apply_stimulus(1'b1, mk(5'd7, 1'b1, 5'd1, 64'h7777), 1'b0, 1'b0, acc);
    apply_stimulus(1'b1, mk(5'd8, 1'b1, 5'd2, 64'h8888), 1'b0, 1'b0, acc);
    apply_stimulus(1'b1, mk(5'd9, 1'b1, 5'd3, 64'h9999), 1'b1, 1'b1, acc);
    apply_stimulus(1'b0, mk(5'd0, 1'b0, 5'd0, 64'd0), 1'b1, 1'b0, acc);

    // Stream retirements until the counter sits at all-ones, then wrap it
    guard = 0;
    while (retire_model != 4'hF && guard < 60) begin
      apply_stimulus(1'b1, rnd_ent(), 1'b1, 1'b0, acc);
      guard++;
    end
    check_output("reached_all_ones", {60'd0, retire_model}, 64'hF);
    if (sb.size() == 0) apply_stimulus(1'b1, rnd_ent(), 1'b0, 1'b0, acc);
    apply_stimulus(1'b0, mk(5'd0, 1'b0, 5'd0, 64'd0), 1'b1, 1'b0, acc);
    check_output("retire_wrap", {60'd0, retire_cnt}, 64'd0);
    repeat (2) apply_stimulus(1'b0, mk(5'd0, 1'b0, 5'd0, 64'd0), 1'b1, 1'b0, acc);

    // Asynchronous reset between edges with one entry buffered
    apply_stimulus(1'b1, mk(5'd10, 1'b1, 5'd4, 64'h4444), 1'b0, 1'b0, acc);
    ex_valid = 1'b0;
    wb_ready = 1'b1;
    #2;
    check_output("pre_arst_wb_valid", {63'd0, wb_valid}, 64'd1);
    rst = 1'b0;
    #1;
    check_output("arst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check_output("arst_rf_wen", {63'd0, rf_wen}, 64'd0);
    check_output("arst_ex_ready", {63'd0, ex_ready}, 64'd0);
    check_output("arst_retire_cnt", {60'd0, retire_cnt}, 64'd0);
    sb.delete();
    retire_model = 4'd0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1'b0, mk(5'd0, 1'b0, 5'd0, 64'd0), 1'b1, 1'b0, acc);

    // Random traffic with occasional flushes
    for (int i = 0; i < 120; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), rnd_ent(), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 15) == 0), acc);
    end
    repeat (3) apply_stimulus(1'b0, mk(5'd0, 1'b0, 5'd0, 64'd0), 1'b1, 1'b0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
